// File: rtl/fifo_ctl.sv
// Parametrised synchronous FIFO with guarded push/pop, thresholds, optional
// first-word-fall-through read, synchronous flush and sticky error/peak status.
module fifo_ctl #(
    parameter int FD    = 8,
    parameter int DW    = 8,
    parameter int AF_TH = FD - 2,
    parameter int AE_TH = 1,
    parameter bit FWFT  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ffflush,
    input  logic                  ffwreq,
    input  logic [DW-1:0]         ffwdata,
    input  logic                  ffrreq,
    output logic [DW-1:0]         ffrdata,
    output logic                  ffrvld,
    output logic [$clog2(FD):0]   ffvcnt,
    output logic                  ffwfull,
    output logic                  ffrempty,
    output logic                  ffafull,
    output logic                  ffaempty,
    output logic                  ffovf,
    output logic                  ffudf,
    input  logic                  errclr,
    output logic [$clog2(FD):0]   ffpeak
);

    localparam int AW = $clog2(FD);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(FD - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FD);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_TH);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_TH);

    logic [DW-1:0] mem_q [FD];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] peak_q, peak_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          full, empty;
    logic          racc, wacc;

    // Pointers wrap explicitly at FD-1 so any depth works, not only powers of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full  = (cnt_q == CNT_FULL);
        empty = (cnt_q == '0);
        racc  = ffrreq & ~empty & ~ffflush;
        wacc  = ffwreq & ~ffflush & (~full | racc);
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (ffflush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wacc) wptr_d = ptr_inc(wptr_q);
            if (racc) rptr_d = ptr_inc(rptr_q);
            case ({wacc, racc})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // A new error in the same cycle as errclr leaves the flag set.
    always_comb begin
        ovf_d = (ffwreq & ~wacc & ~ffflush) | (ovf_q & ~errclr);
        udf_d = (ffrreq & ~racc & ~ffflush) | (udf_q & ~errclr);
        if (errclr)
            peak_d = cnt_d;
        else
            peak_d = (cnt_d > peak_q) ? cnt_d : peak_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            peak_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            peak_q <= peak_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FD; i++) mem_q[i] <= '0;
        end else if (wacc) begin
            mem_q[wptr_q] <= ffwdata;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign ffrdata = mem_q[rptr_q];
            assign ffrvld  = ~empty;
        end else begin : g_reg
            logic [DW-1:0] rdata_q, rdata_d;
            logic          rvld_q, rvld_d;

            // On full with push+pop the read samples the old head before the write lands.
            always_comb begin
                rdata_d = rdata_q;
                rvld_d  = racc;
                if (racc) rdata_d = mem_q[rptr_q];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_q <= '0;
                    rvld_q  <= 1'b0;
                end else begin
                    rdata_q <= rdata_d;
                    rvld_q  <= rvld_d;
                end
            end

            assign ffrdata = rdata_q;
            assign ffrvld  = rvld_q;
        end
    endgenerate

    assign ffvcnt   = cnt_q;
    assign ffwfull  = full;
    assign ffrempty = empty;
    assign ffafull  = (cnt_q >= CNT_AF);
    assign ffaempty = (cnt_q <= CNT_AE);
    assign ffovf    = ovf_q;
    assign ffudf    = udf_q;
    assign ffpeak   = peak_q;

endmodule
